// File: rtl/scan_mux_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : scan_mux_if                                              |
// | Description : Signal bundle for scan_mux. The master side drives the   |
// |               mode/select/enable/hold controls and the packed channel  |
// |               data; the slave side (the mux) returns the registered    |
// |               selection, its channel index, valid and wrap pulse.      |
// | Signals     : mode, sel_in, ch_en, hold, data_in  (master -> slave)    |
// |               out_data, out_ch, out_valid, wrap  (slave -> master)     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface scan_mux_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
);
   logic                         mode;
   logic [SEL_W-1:0]             sel_in;
   logic [CHANNELS-1:0]          ch_en;
   logic                         hold;
   logic [CHANNELS*WIDTH-1:0]    data_in;
   logic [WIDTH-1:0]             out_data;
   logic [SEL_W-1:0]             out_ch;
   logic                         out_valid;
   logic                         wrap;

   modport master (
      output mode, sel_in, ch_en, hold, data_in,
      input  out_data, out_ch, out_valid, wrap
   );

   modport slave (
      input  mode, sel_in, ch_en, hold, data_in,
      output out_data, out_ch, out_valid, wrap
   );
endinterface
`default_nettype wire

// File: rtl/scan_mux.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : scan_mux                                                 |
// | Description : N-channel, W-bit registered multiplexer. In manual mode  |
// |               the external select picks the channel; in scan mode a    |
// |               pointer walks round-robin over the enabled channels,     |
// |               staying DWELL cycles on each.                            |
// | Ports       : clk        system clock, rising edge                     |
// |               rst        asynchronous reset, active-high               |
// |               bus.mode   0 = manual, 1 = scan                          |
// |               bus.sel_in manual channel index                          |
// |               bus.ch_en  per-channel enable mask                       |
// |               bus.hold   scan only: freeze pointer and dwell counter   |
// |               bus.data_in packed channel data                          |
// |               bus.out_data/out_ch/out_valid/wrap  registered results   |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module scan_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int DWELL    = 4
) (
   input  wire          clk,
   input  wire          rst,
   scan_mux_if.slave    bus
);

   localparam int CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int SEL_N   = 2 ** SEL_W;

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_SCAN   = 2'd1,
      ST_NONE   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0]     out_ch_q, out_ch_d;
   logic                 out_valid_q, out_valid_d;
   logic                 wrap_q, wrap_d;

   // Channel data and enables widened to the full select range so any
   // SEL_W-bit index is in bounds; unused slots read as disabled/zero.
   logic [WIDTH-1:0]     w_ch [SEL_N];
   logic [SEL_N-1:0]     w_en_ext;
   logic                 w_sel_legal;
   logic [SEL_W-1:0]     w_ptr_inc;
   logic [SEL_W-1:0]     w_from_ptr;
   logic [SEL_W-1:0]     w_after_ptr;

   genvar gi;
   generate
      for (gi = 0; gi < SEL_N; gi++) begin : g_unpack
         if (gi < CHANNELS) begin : g_real
            assign w_ch[gi] = bus.data_in[gi*WIDTH +: WIDTH];
         end else begin : g_pad
            assign w_ch[gi] = '0;
         end
      end
   endgenerate

   // First enabled channel at or above 'start', searching circularly.
   function automatic logic [SEL_W-1:0] f_first_from(
      input logic [SEL_W-1:0]    start,
      input logic [CHANNELS-1:0] en
   );
      logic [SEL_W-1:0]    res;
      logic [CHANNELS-1:0] sh;
      logic                found;
      int                  idx;
      res   = start;
      found = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         idx = (int'(start) + k) % CHANNELS;
         sh  = en >> idx;
         if (!found && sh[0]) begin
            res   = SEL_W'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   always_comb begin
      w_en_ext                 = '0;
      w_en_ext[CHANNELS-1:0]   = bus.ch_en;
      w_sel_legal              = (int'(bus.sel_in) < CHANNELS);
      w_ptr_inc                = (int'(ptr_q) >= CHANNELS - 1) ? '0 : ptr_q + SEL_W'(1);
      w_from_ptr               = f_first_from(ptr_q, bus.ch_en);
      w_after_ptr              = f_first_from(w_ptr_inc, bus.ch_en);
   end

   always_comb begin
      state_d     = ST_MANUAL;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = 1'b0;
      wrap_d      = 1'b0;

      // Mode is re-evaluated every cycle straight from the inputs.
      if (!bus.mode) begin
         state_d = ST_MANUAL;
      end else if (|bus.ch_en) begin
         state_d = ST_SCAN;
      end else begin
         state_d = ST_NONE;
      end

      case (state_d)
         ST_MANUAL: begin
            cnt_d = '0;
            if (w_sel_legal) begin
               ptr_d = bus.sel_in;
               if (w_en_ext[bus.sel_in]) begin
                  out_data_d  = w_ch[bus.sel_in];
                  out_ch_d    = bus.sel_in;
                  out_valid_d = 1'b1;
               end
            end
         end

         ST_SCAN: begin
            if (state_q != ST_SCAN) begin
               // Entry: start on the pointer if enabled, else the next one up.
               ptr_d = w_from_ptr;
               cnt_d = '0;
            end else if (!w_en_ext[ptr_q]) begin
               // Current channel vanished; leave it at once, even under hold.
               ptr_d  = w_after_ptr;
               cnt_d  = '0;
               wrap_d = (w_after_ptr <= ptr_q);
            end else if (!bus.hold) begin
               if (cnt_q == C_CNT_LAST) begin
                  ptr_d  = w_after_ptr;
                  cnt_d  = '0;
                  wrap_d = (w_after_ptr <= ptr_q);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            out_data_d  = w_ch[ptr_d];
            out_ch_d    = ptr_d;
            out_valid_d = 1'b1;
         end

         default: begin
            cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_MANUAL;
         ptr_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         wrap_q      <= wrap_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;
   assign bus.wrap      = wrap_q;

endmodule
`default_nettype wire
